keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives the calculator's physical key matrix one row at a time and samples the columns.
- Debounces each full matrix frame over several consecutive scans.
- Presents a stable calc_pkg::buttons_t vector for the sanitize_buttons stage, which sits directly downstream.
- Owns all matrix timing, so downstream logic only ever sees clean, synchronous button levels.

Parameters:
- NUM_ROWS, 5, number of matrix rows driven.
- NUM_COLS, 5, number of matrix columns sampled.
- SETTLE_CYCLES, 4, cycles each row is driven before its columns are sampled; must be 2 or more.
- DEBOUNCE_SCANS, 3, consecutive identical frames required before buttons_o updates; must be 2 or more.

Ports:
- clk_i  input  1  clock; single clock domain.
- rst_ni  input  1  reset; synchronous, active-low.
- enable_i  input  1  scan enable.
- col_i  input  NUM_COLS  column sense, active-low (pulled up); low means a key is pressed in the driven row.
- row_o  output  NUM_ROWS  row drive, active-low, at most one bit low.
- buttons_o  output  calc_pkg::buttons_t  debounced button levels.
- scan_done_o  output  1  one-cycle pulse at the end of each full scan.
- ghost_o  output  1  one-cycle pulse when a ghosted frame is rejected (optional feature).

Behaviour:
- Reset values (rst_ni low at posedge): row_o all 1, buttons_o '0, scan_done_o 0, ghost_o 0, FSM in IDLE, frame/last_frame '0, stable_cnt 0.
- FSM states: IDLE, DRIVE, COMMIT.
- IDLE:
  - row_o all 1.
  - enable_i high moves to DRIVE with row=0, settle_cnt=0.
- DRIVE:
  - row_o[row]=0; all other row bits 1.
  - settle_cnt counts 0..SETTLE_CYCLES-1.
  - On the cycle settle_cnt==SETTLE_CYCLES-1, ~col_i is captured into frame[row*NUM_COLS +: NUM_COLS].
  - On that same cycle: if row==NUM_ROWS-1, go to COMMIT; else row++ and settle_cnt=0.
- COMMIT (1 cycle):
  - row_o all 1 and scan_done_o=1.
  - If frame==last_frame: stable_cnt increments, saturating at DEBOUNCE_SCANS-1.
  - Otherwise: last_frame<=frame and stable_cnt<=0.
  - When stable_cnt becomes (or already is) DEBOUNCE_SCANS-1, buttons_o<=map(last_frame), visible the next cycle.
  - Then go to DRIVE with row 0 if enable_i is high, else IDLE.
- Scan period is NUM_ROWS*SETTLE_CYCLES+1 cycles (21 at defaults).
- Press/release latency is DEBOUNCE_SCANS scans, counting the scan in which the change first appears.
- Mapping: frame index i=r*NUM_COLS+c. Indices 0..22 map in order to:
  - on, off, mem_rc, mem_sub, mem_add
  - op_percent, op_sqrt, op_div, op_mul, op_sub, op_add, op_eq
  - dot, num_1..num_9, num_0
  - Indices 23 and above are sampled but ignored.
- enable_i low in DRIVE:
  - Next cycle goes to IDLE with row_o all 1.
  - Partial frame discarded; stable_cnt cleared; buttons_o held.
  - Re-enable restarts at row 0.
- enable_i low in COMMIT: COMMIT completes normally, then goes to IDLE.
- Reset asserted mid-scan: all state returns to reset values on that edge, regardless of FSM state.
- Multiple keys are reported as-is; sanitize_buttons resolves priority.

Optional Feature:
- Macro: KEYPAD_GHOST_REJECT_EN.
- Defined:
  - In COMMIT, the frame is a ghost if any two rows both have 2 or more of the same columns set.
  - A ghost frame is discarded: last_frame, stable_cnt and buttons_o are unchanged.
  - ghost_o pulses with scan_done_o.
- Not defined: ghost_o is tied 0 and every frame enters debounce as captured.

Test Plan:
- Reset check: rst_ni low for 3 cycles, enable_i=1, no keys pressed -> row_o=5'b11111 during reset; after release, row_o walks 11110,11101,11011,10111,01111 with 4 cycles each; scan_done_o pulses every 21 cycles; buttons_o stays 0.
- Single key: col_i[2] held low whenever row_o[3]==0 (num_5), starting at scan 1 -> buttons_o.num_5=1 from the cycle after scan 3's COMMIT and not earlier; all other fields 0. Releasing the key clears num_5 after 3 further scans.
- Bounce: num_0 (row 4, col 2) asserted on alternating scans for 10 scans -> buttons_o never changes.
- Enable drop: enable_i=0 during row 2 of a scan with num_1 pressed -> row_o=11111 the next cycle; buttons_o held. Re-enable -> scan restarts at row 0; 3 fresh scans needed before commit.
- Ghost: press on (0,0), off (0,1) and op_percent (1,0), so op_sqrt (1,1) reads as pressed:
  - With KEYPAD_GHOST_REJECT_EN: ghost_o pulses every scan; buttons_o keeps its prior value.
  - Without it: after 3 scans on, off, op_percent and op_sqrt all read 1.
- Unused position: row 4 col 4 pressed -> buttons_o stays 0.

Source files
------------

// File: rtl/keypad_scanner.sv
// Row-scanned key matrix reader with whole-frame debounce, feeding sanitize_buttons.
// Build option: define KEYPAD_GHOST_REJECT_EN to discard frames showing the matrix ghost pattern.

package calc_pkg;
    // Declared MSB-first so that packed bit i equals matrix frame index i.
    typedef struct packed {
        logic num_0;
        logic num_9;
        logic num_8;
        logic num_7;
        logic num_6;
        logic num_5;
        logic num_4;
        logic num_3;
        logic num_2;
        logic num_1;
        logic dot;
        logic op_eq;
        logic op_add;
        logic op_sub;
        logic op_mul;
        logic op_div;
        logic op_sqrt;
        logic op_percent;
        logic mem_add;
        logic mem_sub;
        logic mem_rc;
        logic off;
        logic on;
    } buttons_t;
endpackage

module keypad_scanner #(
    parameter int NUM_ROWS       = 5,
    parameter int NUM_COLS       = 5,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [NUM_COLS-1:0] col_i,
    output logic [NUM_ROWS-1:0] row_o,
    output calc_pkg::buttons_t  buttons_o,
    output logic                scan_done_o,
    output logic                ghost_o
);
    localparam int FRAME_W = NUM_ROWS * NUM_COLS;
    localparam int MAP_W   = $bits(calc_pkg::buttons_t);
    localparam int PAD_W   = (FRAME_W > MAP_W) ? FRAME_W : MAP_W;
    localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int SET_W   = $clog2(SETTLE_CYCLES);
    localparam int STB_W   = $clog2(DEBOUNCE_SCANS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Positions beyond the button set are zero-padded or dropped here.
    function automatic calc_pkg::buttons_t map_frame(input logic [FRAME_W-1:0] f);
        logic [PAD_W-1:0] pad;
        pad = PAD_W'(f);
        return calc_pkg::buttons_t'(pad[MAP_W-1:0]);
    endfunction

`ifdef KEYPAD_GHOST_REJECT_EN
    function automatic logic is_ghost(input logic [FRAME_W-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int a = 0; a < NUM_ROWS; a++) begin
            for (int b = a + 32'sd1; b < NUM_ROWS; b++) begin
                if ($countones(f[a*NUM_COLS +: NUM_COLS] & f[b*NUM_COLS +: NUM_COLS]) >= 32'sd2) begin
                    hit = 1'b1;
                end else begin
                    hit = hit;
                end
            end
        end
        return hit;
    endfunction
`endif

    state_e               state_q,   state_d;
    logic [ROW_W-1:0]     row_q,     row_d;
    logic [SET_W-1:0]     settle_q,  settle_d;
    logic [FRAME_W-1:0]   frame_q,   frame_d;
    logic [FRAME_W-1:0]   last_q,    last_d;
    logic [STB_W-1:0]     stable_q,  stable_d;
    calc_pkg::buttons_t   buttons_q, buttons_d;
    logic [NUM_ROWS-1:0]  rows_q,    rows_d;
    logic                 done_q,    done_d;
    logic                 ghost_q,   ghost_d;
    logic [FRAME_W-1:0]   frame_cap_s;

    // Current frame with the driven row's slice replaced by the live column sense.
    always_comb begin
        frame_cap_s = frame_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_q == ROW_W'(r)) begin
                frame_cap_s[r*NUM_COLS +: NUM_COLS] = ~col_i;
            end else begin
                frame_cap_s[r*NUM_COLS +: NUM_COLS] = frame_q[r*NUM_COLS +: NUM_COLS];
            end
        end
    end

    // Scan sequencing, debounce and next values of all registered outputs.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        settle_d  = settle_q;
        frame_d   = frame_q;
        last_d    = last_q;
        stable_d  = stable_q;
        buttons_d = buttons_q;
        rows_d    = '1;
        done_d    = 1'b0;
        ghost_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d  = ST_DRIVE;
                    row_d    = '0;
                    settle_d = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (!enable_i) begin
                    // Clearing last_frame too makes a resumed scan earn a full debounce run.
                    state_d  = ST_IDLE;
                    frame_d  = '0;
                    last_d   = '0;
                    stable_d = '0;
                end else if (settle_q == SET_LAST) begin
                    frame_d = frame_cap_s;
                    if (row_q == ROW_LAST) begin
                        state_d = ST_COMMIT;
                        done_d  = 1'b1;
`ifdef KEYPAD_GHOST_REJECT_EN
                        ghost_d = is_ghost(frame_cap_s);
`endif
                    end else begin
                        row_d    = row_q + 1'b1;
                        settle_d = '0;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                if (ghost_q) begin
                    last_d = last_q;
                end else if (frame_q == last_q) begin
                    if (stable_q != STB_LAST) begin
                        stable_d = stable_q + 1'b1;
                    end else begin
                        stable_d = STB_LAST;
                    end
                    if (stable_d == STB_LAST) begin
                        buttons_d = map_frame(frame_q);
                    end else begin
                        buttons_d = buttons_q;
                    end
                end else begin
                    last_d   = frame_q;
                    stable_d = '0;
                end
                if (enable_i) begin
                    state_d  = ST_DRIVE;
                    row_d    = '0;
                    settle_d = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_DRIVE) begin
            rows_d[row_d] = 1'b0;
        end else begin
            rows_d = '1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            settle_q  <= '0;
            frame_q   <= '0;
            last_q    <= '0;
            stable_q  <= '0;
            buttons_q <= '0;
            rows_q    <= '1;
            done_q    <= 1'b0;
            ghost_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            settle_q  <= settle_d;
            frame_q   <= frame_d;
            last_q    <= last_d;
            stable_q  <= stable_d;
            buttons_q <= buttons_d;
            rows_q    <= rows_d;
            done_q    <= done_d;
            ghost_q   <= ghost_d;
        end
    end

    assign row_o       = rows_q;
    assign buttons_o   = buttons_q;
    assign scan_done_o = done_q;
    assign ghost_o     = ghost_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a scan-timeline model checked every cycle plus literal checkpoints.
// Honours KEYPAD_GHOST_REJECT_EN the same way as the design build.
module tb_keypad_scanner;
    localparam int NR     = 5;
    localparam int NC     = 5;
    localparam int SC     = 4;
    localparam int DS     = 3;
    localparam int PERIOD = NR * SC + 1;
`ifdef KEYPAD_GHOST_REJECT_EN
    localparam bit GHOST_EN = 1'b1;
`else
    localparam bit GHOST_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [NC-1:0]      col;
    logic [NR-1:0]      row;
    calc_pkg::buttons_t buttons;
    logic               scan_done;
    logic               ghost;
    logic [NR*NC-1:0]   pressed;
    bit                 chk_en = 1'b0;
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.NUM_ROWS(NR), .NUM_COLS(NC), .SETTLE_CYCLES(SC), .DEBOUNCE_SCANS(DS)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .enable_i   (enable),
        .col_i      (col),
        .row_o      (row),
        .buttons_o  (buttons),
        .scan_done_o(scan_done),
        .ghost_o    (ghost)
    );

    // Passive matrix: a driven (low) row pulls low every column with a pressed key.
    always_comb begin
        col = '1;
        for (int r = 0; r < NR; r++) begin
            if (row[r] === 1'b0) col = col & ~pressed[r*NC +: NC];
        end
    end

    function automatic calc_pkg::buttons_t to_buttons(input logic [22:0] v);
        calc_pkg::buttons_t b;
        b.on = v[0];  b.off = v[1];  b.mem_rc = v[2];  b.mem_sub = v[3];  b.mem_add = v[4];
        b.op_percent = v[5]; b.op_sqrt = v[6]; b.op_div = v[7]; b.op_mul = v[8];
        b.op_sub = v[9]; b.op_add = v[10]; b.op_eq = v[11]; b.dot = v[12];
        b.num_1 = v[13]; b.num_2 = v[14]; b.num_3 = v[15]; b.num_4 = v[16]; b.num_5 = v[17];
        b.num_6 = v[18]; b.num_7 = v[19]; b.num_8 = v[20]; b.num_9 = v[21]; b.num_0 = v[22];
        return b;
    endfunction

    function automatic bit ghost_frame(input logic [NR*NC-1:0] f);
        bit hit = 1'b0;
        for (int a = 0; a < NR; a++)
            for (int b = a + 1; b < NR; b++)
                if ($countones(f[a*NC +: NC] & f[b*NC +: NC]) >= 2) hit = 1'b1;
        return GHOST_EN && hit;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within a scan (m_t 0..NR*SC, NR*SC is the commit cycle) and a run of identical frames.
    bit               m_active;
    int               m_t;
    int               m_run;
    logic [NR*NC-1:0] m_frame, m_last;
    logic [22:0]      m_btn;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0; m_t = 0; m_frame = '0; m_last = '0; m_run = 1; m_btn = '0;
        end else if (!m_active) begin
            if (enable) begin m_active = 1'b1; m_t = 0; end
        end else if (m_t < NR * SC) begin
            if (!enable) begin
                m_active = 1'b0; m_frame = '0; m_last = '0; m_run = 1;
            end else begin
                if (m_t % SC == SC - 1) m_frame[(m_t / SC) * NC +: NC] = pressed[(m_t / SC) * NC +: NC];
                m_t++;
            end
        end else begin
            if (!ghost_frame(m_frame)) begin
                if (m_frame == m_last) m_run++;
                else begin m_last = m_frame; m_run = 1; end
                if (m_run >= DS) m_btn = m_last[22:0];
            end
            if (enable) m_t = 0;
            else m_active = 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NR-1:0] exp_row;
            bit            exp_done;
            exp_row  = (m_active && m_t < NR * SC) ? ~(5'b00001 << (m_t / SC)) : 5'b11111;
            exp_done = m_active && (m_t == NR * SC);
            check("model_row", 32'(row), 32'(exp_row));
            check("model_done", 32'(scan_done), 32'(exp_done));
            check("model_ghost", 32'(ghost), 32'(exp_done && ghost_frame(m_frame)));
            check("model_buttons", {9'd0, buttons}, {9'd0, to_buttons(m_btn)});
        end
    end

    task automatic wait_done(input string tag);
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (scan_done === 1'b1) break;
        end
        check(tag, 32'(scan_done), 32'd1);
    endtask

    task automatic wait_row(input logic [NR-1:0] r, input string tag);
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (row === r) break;
        end
        check(tag, 32'(row), 32'(r));
    endtask

    logic [NR-1:0] walk_tbl [NR] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};

    initial begin
        int n;
        rst_n = 1'b0; enable = 1'b1; pressed = '0;
        @(posedge clk); #1 chk_en = 1'b1;
        @(negedge clk); @(negedge clk);
        check("reset_row", 32'(row), 32'h1f);
        check("reset_buttons", {9'd0, buttons}, 32'd0);
        check("reset_done", 32'(scan_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            check("walk_row", 32'(row), (k < NR * SC) ? 32'(walk_tbl[k / SC]) : 32'h1f);
            check("walk_done", 32'(scan_done), (k == NR * SC) ? 32'd1 : 32'd0);
        end
        for (n = 1; n < 100; n++) begin
            @(negedge clk);
            if (scan_done === 1'b1) break;
        end
        check("scan_period", 32'(n), 32'd21);

        // num_5 at row 3 col 2
        pressed[17] = 1'b1;
        wait_done("num5_s1"); wait_done("num5_s2"); wait_done("num5_s3");
        check("num5_early", 32'(buttons.num_5), 32'd0);
        @(negedge clk);
        check("num5_set", 32'(buttons.num_5), 32'd1);
        check("num5_only", 32'($countones(buttons)), 32'd1);
        pressed = '0;
        wait_done("rel_s1"); wait_done("rel_s2"); wait_done("rel_s3");
        check("rel_early", 32'(buttons.num_5), 32'd1);
        @(negedge clk);
        check("rel_clear", {9'd0, buttons}, 32'd0);

        // num_0 bouncing on alternate scans
        pressed[22] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_done("bounce");
            pressed[22] = ~pressed[22];
        end
        check("bounce_held", {9'd0, buttons}, 32'd0);

        // unused matrix position row 4 col 4
        pressed = '0; pressed[24] = 1'b1;
        repeat (4) wait_done("unused");
        @(negedge clk);
        check("unused_zero", {9'd0, buttons}, 32'd0);
        pressed = '0;
        repeat (3) wait_done("idle_scan");

        // enable drop in row 2 while num_1 (row 2 col 3) is held
        pressed[13] = 1'b1;
        wait_done("drop_s1");
        wait_row(5'b11011, "drop_row2");
        enable = 1'b0;
        @(negedge clk);
        check("drop_row", 32'(row), 32'h1f);
        check("drop_buttons", {9'd0, buttons}, 32'd0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("restart_row0", 32'(row), 32'h1e);
        wait_done("re_s1"); wait_done("re_s2");
        @(negedge clk);
        check("re_early", 32'(buttons.num_1), 32'd0);
        wait_done("re_s3");
        @(negedge clk);
        check("re_set", 32'(buttons.num_1), 32'd1);

        // reset in the middle of row 3
        wait_row(5'b10111, "mid_row3");
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_row", 32'(row), 32'h1f);
        check("midrst_buttons", {9'd0, buttons}, 32'd0);
        rst_n = 1'b1;

        // ghost square: on, off, op_percent and op_sqrt
        pressed = '0;
        pressed[0] = 1'b1; pressed[1] = 1'b1; pressed[5] = 1'b1; pressed[6] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done("ghost_scan");
            check("ghost_pulse", 32'(ghost), GHOST_EN ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("ghost_buttons", {9'd0, buttons}, GHOST_EN ? 32'd0 : 32'h63);
        check("ghost_sqrt", 32'(buttons.op_sqrt), GHOST_EN ? 32'd0 : 32'd1);

        enable = 1'b0;
        repeat (30) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
